// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with hold, load, shift, rotate, inc/dec modes plus serial and flag outputs
module universal_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D_in,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q,
  output logic             sout,
  output logic             carry,
  output logic             zero
);
  logic [WIDTH-1:0] q_n;
  logic sout_n, carry_n;
  logic [WIDTH:0] inc, dec;
  assign inc = {1'b0, Q} + {{WIDTH{1'b0}}, 1'b1};
  assign dec = {1'b0, Q} - {{WIDTH{1'b0}}, 1'b1};
  always_comb begin
    q_n = Q;
    sout_n = sout;
    carry_n = carry;
    if (en)
      case (mode)
        3'd1: q_n = D_in;
        3'd2: {sout_n, q_n} = {Q, sin_r};
        3'd3: {q_n, sout_n} = {sin_l, Q};
        3'd4: {sout_n, q_n} = {Q, Q[WIDTH-1]};
        3'd5: {q_n, sout_n} = {Q[0], Q};
        3'd6: {carry_n, q_n} = inc;
        3'd7: {carry_n, q_n} = dec;
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      Q <= RESET_VAL;
      sout <= 1'b0;
      carry <= 1'b0;
    end else begin
      Q <= q_n;
      sout <= sout_n;
      carry <= carry_n;
    end
  assign not_Q = ~Q;
  assign zero = ~|Q;
endmodule
